// File: rtl/tmds_channel_encoder_if.sv
// Video-in / TMDS-symbol-out bundle for the TMDS channel encoder.
// Driven by the pixel pipeline (master) and consumed by the encoder (slave).
interface tmds_channel_encoder_if;
  logic       de;
  logic       hsync;
  logic       vsync;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic [9:0] tmds_ch0;
  logic [9:0] tmds_ch1;
  logic [9:0] tmds_ch2;

  modport master (
    output de, hsync, vsync,
    output red, green, blue,
    input  tmds_ch0, tmds_ch1, tmds_ch2
  );

  modport slave (
    input  de, hsync, vsync,
    input  red, green, blue,
    output tmds_ch0, tmds_ch1, tmds_ch2
  );
endinterface

// File: rtl/tmds_channel_encoder.sv
// Three-channel DVI/TMDS 8b/10b encoder, two-stage pipeline, pixel clock.
// Link is held on the C=00 token until PLL lock is qualified.
module tmds_channel_encoder #(
  parameter int unsigned LOCK_HOLD = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_lock,
  tmds_channel_encoder_if.slave vid,
  output logic link_up
);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_COUNT,
    ST_UP
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(LOCK_HOLD - 1);
  localparam logic [9:0]  TOK_00    = 10'b1101010100;

  function automatic logic [9:0] token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = 10'b1101010100;
      2'b01:   t = 10'b0010101011;
      2'b10:   t = 10'b0101010100;
      default: t = 10'b1010101011;
    endcase
    return t;
  endfunction

  state_t      state_q;
  logic        lock_meta_q;
  logic [15:0] hold_q;
  logic        link_up_q;

  // The state register acts as the second synchronizer stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      lock_meta_q <= 1'b0;
      hold_q      <= '0;
      link_up_q   <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      unique case (state_q)
        ST_WAIT: begin
          if (lock_meta_q) begin
            state_q <= ST_COUNT;
            hold_q  <= '0;
          end
        end
        ST_COUNT: begin
          if (!lock_meta_q) begin
            state_q   <= ST_WAIT;
            hold_q    <= '0;
            link_up_q <= 1'b0;
          end else if (hold_q == HOLD_LAST) begin
            state_q   <= ST_UP;
            link_up_q <= 1'b1;
          end else begin
            hold_q <= hold_q + 16'd1;
          end
        end
        ST_UP: begin
          if (!lock_meta_q) begin
            state_q   <= ST_WAIT;
            hold_q    <= '0;
            link_up_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_WAIT;
          hold_q    <= '0;
          link_up_q <= 1'b0;
        end
      endcase
    end
  end

  assign link_up = link_up_q;

  logic [7:0] pix [3];
  assign pix[0] = vid.blue;
  assign pix[1] = vid.green;
  assign pix[2] = vid.red;

  logic       de_q;
  logic [1:0] ctl_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de_q  <= 1'b0;
      ctl_q <= 2'b00;
    end else begin
      de_q  <= link_up_q & vid.de;
      ctl_q <= link_up_q ? {vid.vsync, vid.hsync} : 2'b00;
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [3:0]        ones_d;
    logic              use_xnor;
    logic [8:0]        qm_d;
    logic [8:0]        qm_q;
    logic signed [4:0] n1;
    logic signed [4:0] diff;
    logic signed [4:0] cnt_d;
    logic signed [4:0] cnt_q;
    logic [9:0]        sym_d;
    logic [9:0]        sym_q;
    logic [1:0]        ctl;

    always_comb begin
      ones_d   = 4'($countones(pix[c]));
      use_xnor = (ones_d > 4'd4) ||
                 (ones_d == 4'd4 && !pix[c][0]);
      qm_d     = '0;
      qm_d[0]  = pix[c][0];
      for (int i = 1; i < 8; i++) begin
        qm_d[i] = qm_d[i-1] ^ pix[c][i] ^ use_xnor;
      end
      qm_d[8] = ~use_xnor;
    end

    assign ctl = (c == 0) ? ctl_q : 2'b00;

    // diff is n1 - n0 of q_m[7:0]
    always_comb begin
      n1    = 5'($countones(qm_q[7:0]));
      diff  = n1 - (5'sd8 - n1);
      sym_d = token(ctl);
      cnt_d = 5'sd0;
      if (de_q) begin
        if (cnt_q == 5'sd0 || diff == 5'sd0) begin
          sym_d = {~qm_q[8], qm_q[8],
                   qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
          cnt_d = qm_q[8] ? cnt_q + diff : cnt_q - diff;
        end else if ((cnt_q > 5'sd0 && diff > 5'sd0) ||
                     (cnt_q < 5'sd0 && diff < 5'sd0)) begin
          sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
          cnt_d = cnt_q - diff +
                  (qm_q[8] ? 5'sd2 : 5'sd0);
        end else begin
          sym_d = {1'b0, qm_q[8], qm_q[7:0]};
          cnt_d = cnt_q + diff -
                  (qm_q[8] ? 5'sd0 : 5'sd2);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        qm_q  <= '0;
        sym_q <= TOK_00;
        cnt_q <= 5'sd0;
      end else begin
        qm_q  <= qm_d;
        sym_q <= sym_d;
        cnt_q <= cnt_d;
      end
    end
  end

  assign vid.tmds_ch0 = g_ch[0].sym_q;
  assign vid.tmds_ch1 = g_ch[1].sym_q;
  assign vid.tmds_ch2 = g_ch[2].sym_q;

endmodule
